// File: rtl/llc_input_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : llc_input_arbiter
//  Purpose  : N-channel LLC front-end. Picks one eligible input channel per
//             cycle (fixed priority or round-robin), gated by MSHR
//             availability and per-channel stall, splits the winning line
//             address into tag/set and presents it through a registered
//             valid/ready output stage.
//  Revision : 1.0 - initial release
// ============================================================================
module llc_input_arbiter #(
  parameter int                N_CH        = 4,
  parameter int                LINE_ADDR_W = 26,
  parameter int                SET_BITS    = 9,
  parameter int                N_MSHR      = 8,
  parameter int                MSHR_W      = 4,
  parameter logic [N_CH-1:0]   RSP_MASK    = 4'b0001,
  parameter bit                RR_MODE     = 1'b0,
  localparam int               CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int               TAG_W       = LINE_ADDR_W - SET_BITS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          decode_en,
  input  logic [N_CH-1:0]               in_valid,
  output logic [N_CH-1:0]               in_ready,
  input  logic [N_CH*LINE_ADDR_W-1:0]   in_addr,
  input  logic [N_CH-1:0]               ch_stall,
  input  logic [MSHR_W-1:0]             mshr_free_cnt,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CH_W-1:0]               out_ch,
  output logic                          out_is_rsp,
  output logic [TAG_W-1:0]              out_tag,
  output logic [SET_BITS-1:0]           out_set
);

  // Output stage and arbitration state
  logic                   out_valid_q,  out_valid_d;
  logic [CH_W-1:0]        out_ch_q,     out_ch_d;
  logic                   out_is_rsp_q, out_is_rsp_d;
  logic [TAG_W-1:0]       out_tag_q,    out_tag_d;
  logic [SET_BITS-1:0]    out_set_q,    out_set_d;
  logic [CH_W-1:0]        rr_ptr_q,     rr_ptr_d;

  logic [N_CH-1:0]        w_elig;
  logic                   w_can_load;
  logic                   w_gnt_vld;
  logic [CH_W-1:0]        w_gnt_idx;
  logic [CH_W-1:0]        w_ptr_next;
  logic [LINE_ADDR_W-1:0] w_sel_addr;
  logic [N_CH-1:0]        w_in_ready;

  // A new entry may load when enabled and the output slot is empty or retiring
  assign w_can_load = decode_en && (!out_valid_q || out_ready);

  // Per-channel eligibility: responses need an occupied MSHR, requests a free one
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (RSP_MASK[i]) begin
        w_elig[i] = in_valid[i] && (mshr_free_cnt != MSHR_W'(N_MSHR));
      end else begin
        w_elig[i] = in_valid[i] && (mshr_free_cnt != '0) && !ch_stall[i];
      end
    end
  end

  // Winner selection; scanning downward and overwriting leaves the first hit
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    if (RR_MODE) begin
      for (int k = N_CH - 1; k >= 0; k--) begin
        int idx;
        idx = int'(rr_ptr_q) + k;
        if (idx >= N_CH) begin
          idx = idx - N_CH;
        end
        if (w_elig[idx]) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = CH_W'(idx);
        end
      end
    end else begin
      for (int i = N_CH - 1; i >= 0; i--) begin
        if (w_elig[i]) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = CH_W'(i);
        end
      end
    end
  end

  // Round-robin pointer advances to the channel after the winner, wrapping
  assign w_ptr_next = (w_gnt_idx == CH_W'(N_CH - 1)) ? '0 : w_gnt_idx + 1'b1;

  // Address of the winning channel
  always_comb begin
    w_sel_addr = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (w_gnt_idx == CH_W'(i)) begin
        w_sel_addr = in_addr[i*LINE_ADDR_W +: LINE_ADDR_W];
      end
    end
  end

  // One-hot accept for the winner; suppressed while in reset
  always_comb begin
    w_in_ready = '0;
    if (w_can_load && w_gnt_vld && !rst) begin
      w_in_ready[w_gnt_idx] = 1'b1;
    end
  end

  assign in_ready = w_in_ready;

  // Next state of the output slot: load on grant, drain when consumed, else hold
  always_comb begin
    out_valid_d  = out_valid_q;
    out_ch_d     = out_ch_q;
    out_is_rsp_d = out_is_rsp_q;
    out_tag_d    = out_tag_q;
    out_set_d    = out_set_q;
    rr_ptr_d     = rr_ptr_q;
    if (w_can_load) begin
      out_valid_d = w_gnt_vld;
      if (w_gnt_vld) begin
        out_ch_d     = w_gnt_idx;
        out_is_rsp_d = RSP_MASK[w_gnt_idx];
        out_tag_d    = w_sel_addr[LINE_ADDR_W-1:SET_BITS];
        out_set_d    = w_sel_addr[SET_BITS-1:0];
        if (RR_MODE) begin
          rr_ptr_d = w_ptr_next;
        end
      end
    end else if (out_ready) begin
      // Entry consumed while arbitration is disabled: never present it twice
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset; reset discards any held entry
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_ch_q     <= '0;
      out_is_rsp_q <= 1'b0;
      out_tag_q    <= '0;
      out_set_q    <= '0;
      rr_ptr_q     <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_ch_q     <= out_ch_d;
      out_is_rsp_q <= out_is_rsp_d;
      out_tag_q    <= out_tag_d;
      out_set_q    <= out_set_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_ch     = out_ch_q;
  assign out_is_rsp = out_is_rsp_q;
  assign out_tag    = out_tag_q;
  assign out_set    = out_set_q;

endmodule
`default_nettype wire

// File: tb/tb_llc_input_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_llc_input_arbiter
//  Purpose  : Scoreboard bench for llc_input_arbiter; one fixed-priority and
//             one round-robin instance share the stimulus, a selector picks
//             which one is being checked.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_llc_input_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        decode_en = 1'b1;
  logic [3:0]  in_valid = '0;
  logic [3:0]  ch_stall = '0;
  logic [3:0]  mshr_free_cnt = 4'd3;
  logic        out_ready = 1'b1;
  logic [103:0] in_addr;
  logic        sel = 1'b0;

  logic [3:0]  fp_in_ready, rr_in_ready;
  logic        fp_valid, rr_valid, fp_rsp, rr_rsp;
  logic [1:0]  fp_ch, rr_ch;
  logic [16:0] fp_tag, rr_tag;
  logic [8:0]  fp_set, rr_set;

  logic [3:0]  m_in_ready;
  logic        m_valid, m_rsp;
  logic [1:0]  m_ch;
  logic [16:0] m_tag;
  logic [8:0]  m_set;

  logic [25:0] addr_tab [4];
  logic [28:0] sb_q [$];
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  initial begin
    addr_tab[0] = 26'h0ABCDEF;
    addr_tab[1] = 26'h1234567;
    addr_tab[2] = 26'h2FEDCBA;
    addr_tab[3] = 26'h3C0FFEE;
  end
  assign in_addr = {addr_tab[3], addr_tab[2], addr_tab[1], addr_tab[0]};

  llc_input_arbiter #(.N_CH(4), .LINE_ADDR_W(26), .SET_BITS(9), .N_MSHR(8),
                      .MSHR_W(4), .RSP_MASK(4'b0001), .RR_MODE(1'b0)) dut_fp (
    .clk(clk), .rst(rst), .decode_en(decode_en), .in_valid(in_valid),
    .in_ready(fp_in_ready), .in_addr(in_addr), .ch_stall(ch_stall),
    .mshr_free_cnt(mshr_free_cnt), .out_valid(fp_valid), .out_ready(out_ready),
    .out_ch(fp_ch), .out_is_rsp(fp_rsp), .out_tag(fp_tag), .out_set(fp_set));

  llc_input_arbiter #(.N_CH(4), .LINE_ADDR_W(26), .SET_BITS(9), .N_MSHR(8),
                      .MSHR_W(4), .RSP_MASK(4'b0001), .RR_MODE(1'b1)) dut_rr (
    .clk(clk), .rst(rst), .decode_en(decode_en), .in_valid(in_valid),
    .in_ready(rr_in_ready), .in_addr(in_addr), .ch_stall(ch_stall),
    .mshr_free_cnt(mshr_free_cnt), .out_valid(rr_valid), .out_ready(out_ready),
    .out_ch(rr_ch), .out_is_rsp(rr_rsp), .out_tag(rr_tag), .out_set(rr_set));

  assign m_in_ready = sel ? rr_in_ready : fp_in_ready;
  assign m_valid    = sel ? rr_valid    : fp_valid;
  assign m_ch       = sel ? rr_ch       : fp_ch;
  assign m_rsp      = sel ? rr_rsp      : fp_rsp;
  assign m_tag      = sel ? rr_tag      : fp_tag;
  assign m_set      = sel ? rr_set      : fp_set;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Expected entry for a channel: {ch, is_rsp, tag, set}; only ch0 is response-class
  function automatic logic [28:0] mk(input int ch);
    logic [25:0] a;
    a = addr_tab[ch];
    return {2'(ch), (ch == 0), a[25:9], a[8:0]};
  endfunction

  // Monitor: every retiring output entry must match the head of the scoreboard
  always @(negedge clk) begin
    if (!rst && m_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_entry", {3'd0, m_ch, m_rsp, m_tag, m_set}, 32'hFFFF_FFFF);
      end else begin
        logic [28:0] e;
        e = sb_q.pop_front();
        chk("sb_entry", {3'd0, m_ch, m_rsp, m_tag, m_set}, {3'd0, e});
      end
    end
  end

  // One cycle: apply in_valid, check in_ready, record the expected grant
  task automatic cyc(input logic [3:0] v, input logic [3:0] exp_rdy, input string nm);
    in_valid = v;
    @(negedge clk);
    chk(nm, {28'd0, m_in_ready}, {28'd0, exp_rdy});
    for (int i = 0; i < 4; i++) if (exp_rdy[i]) sb_q.push_back(mk(i));
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input string nm);
    rst = 1'b1;
    @(negedge clk);
    chk({nm, "_in_ready"}, {28'd0, m_in_ready}, 32'd0);
    @(posedge clk); #1;
    sb_q.delete();
    rst = 1'b0;
    chk({nm, "_outputs"}, {3'd0, m_valid, m_ch, m_rsp, m_tag, m_set}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    @(posedge clk); #1;
    in_valid = 4'b1111;
    do_reset("reset0");

    // ---------------- fixed-priority instance ----------------
    sel = 1'b0;
    mshr_free_cnt = 4'd3;
    cyc(4'b1111, 4'b0001, "fp_prio");
    chk("fp_tag_literal", {15'd0, m_tag}, 32'h55E6);
    chk("fp_set_literal", {23'd0, m_set}, 32'h1EF);
    mshr_free_cnt = 4'd0;
    cyc(4'b0011, 4'b0001, "fp_mshr0");
    mshr_free_cnt = 4'd8;
    cyc(4'b0011, 4'b0010, "fp_mshr_full");
    mshr_free_cnt = 4'd0;
    cyc(4'b0010, 4'b0000, "fp_mshr0_req_only");
    chk("fp_idle_valid", {31'd0, m_valid}, 32'd0);
    mshr_free_cnt = 4'd4;
    ch_stall = 4'b0110;
    cyc(4'b0110, 4'b0000, "fp_all_stalled");
    chk("fp_stalled_valid", {31'd0, m_valid}, 32'd0);
    ch_stall = 4'b0010;
    cyc(4'b0110, 4'b0100, "fp_stall_release");
    ch_stall = 4'b0000;

    // back-pressure: ch2 entry held for three cycles while ch3 waits
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(4'b1000, 4'b0000, "fp_bp_in_ready");
      chk("fp_bp_hold", {3'd0, m_valid, m_ch, m_rsp, m_tag, m_set}, {3'd1, mk(2)});
    end
    out_ready = 1'b1;
    cyc(4'b1000, 4'b1000, "fp_bp_release");
    chk("fp_bp_load_ch3", {30'd0, m_ch}, 32'd3);
    cyc(4'b0000, 4'b0000, "fp_drain");
    chk("fp_drained_valid", {31'd0, m_valid}, 32'd0);
    decode_en = 1'b0;
    cyc(4'b1111, 4'b0000, "fp_decode_off");
    decode_en = 1'b1;

    // ---------------- round-robin instance ----------------
    sel = 1'b1;
    mshr_free_cnt = 4'd3;
    do_reset("reset_rr");
    cyc(4'b1111, 4'b0001, "rr_all_0");
    cyc(4'b1111, 4'b0010, "rr_all_1");
    cyc(4'b1111, 4'b0100, "rr_all_2");
    cyc(4'b1111, 4'b1000, "rr_all_3");
    cyc(4'b1111, 4'b0001, "rr_all_wrap0");
    cyc(4'b1111, 4'b0010, "rr_all_wrap1");
    cyc(4'b0000, 4'b0000, "rr_idle");

    do_reset("reset_rr2");
    cyc(4'b1111, 4'b0001, "rr_skip_0");
    cyc(4'b1101, 4'b0100, "rr_skip_2");
    cyc(4'b1101, 4'b1000, "rr_skip_3");
    cyc(4'b1101, 4'b0001, "rr_skip_wrap0");
    cyc(4'b0000, 4'b0000, "rr_skip_idle");

    // reset while holding an entry with rr_ptr = 2
    do_reset("reset_rr3");
    cyc(4'b1111, 4'b0001, "rr_pre_0");
    cyc(4'b1111, 4'b0010, "rr_pre_1");
    out_ready = 1'b0;
    cyc(4'b0000, 4'b0000, "rr_hold");
    chk("rr_hold_entry", {29'd0, m_valid, m_ch}, 32'd5);
    in_valid = 4'b1111;
    do_reset("reset_midhold");
    out_ready = 1'b1;
    cyc(4'b1111, 4'b0001, "rr_after_reset");
    cyc(4'b0000, 4'b0000, "rr_final_idle");

    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("sb_empty", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/llc_input_arbiter.md
Name: llc_input_arbiter

Overview:
- Parametrised N-channel front-end for the LLC pipeline.
- Each cycle it selects one valid input channel (responses, requests, DMA, etc.), gated by MSHR availability and per-channel stall.
- It splits the winning line address into tag/set and presents the result through a registered valid/ready stage to the LLC core.
- Generalises the two-input fixed-priority decoder to N channels, a configurable per-channel class, fixed-priority or round-robin mode, and downstream back-pressure.

Parameters:
- N_CH, 4, number of input channels (2..8).
- LINE_ADDR_W, 26, line address width (ADDR_BITS - OFFSET_BITS).
- SET_BITS, 9, LLC set index width; tag width TAG_W = LINE_ADDR_W - SET_BITS.
- N_MSHR, 8, number of MSHR entries.
- MSHR_W, 4, width of mshr_free_cnt (holds 0..N_MSHR).
- RSP_MASK, 4'b0001, bit i = 1: channel i is response-class; 0: request-class.
- RR_MODE, 0, 0 = fixed priority (lowest index wins); 1 = round-robin.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- decode_en  in  1  arbitration enable from the LLC control FSM.
- in_valid  in  N_CH  per-channel valid.
- in_ready  out  N_CH  per-channel accept, combinational, at most one bit set.
- in_addr  in  N_CH*LINE_ADDR_W  per-channel line address; channel i occupies bits [i*LINE_ADDR_W +: LINE_ADDR_W].
- ch_stall  in  N_CH  per-channel stall (e.g. evict_stall); blocks request-class channels only.
- mshr_free_cnt  in  MSHR_W  free MSHR entries.
- out_valid  out  1  registered decoded-entry valid.
- out_ready  in  1  downstream accept.
- out_ch  out  clog2(N_CH)  index of the granted channel.
- out_is_rsp  out  1  RSP_MASK bit of the granted channel.
- out_tag  out  TAG_W  tag = addr[LINE_ADDR_W-1:SET_BITS].
- out_set  out  SET_BITS  set = addr[SET_BITS-1:0].

Behaviour:
- Eligibility of channel i:
  - response-class: in_valid[i] && mshr_free_cnt != N_MSHR.
  - request-class: in_valid[i] && mshr_free_cnt != 0 && !ch_stall[i].
- can_load = decode_en && (!out_valid || out_ready).
  - With can_load=0: in_ready = 0, no grant, arbitration state unchanged.
- Grant, fixed mode (RR_MODE=0): lowest-index eligible channel.
- Grant, round-robin mode (RR_MODE=1):
  - Search starts at rr_ptr and wraps modulo N_CH; first eligible channel wins.
  - rr_ptr is updated to (grant+1) mod N_CH only on a grant.
  - rr_ptr wraps from N_CH-1 to 0.
- Handshake:
  - in_ready[g] = 1 in the grant cycle; transfer occurs when in_valid && in_ready.
  - Sources must not depend on in_ready to drive in_valid.
- Latency: 1 cycle.
  - On a grant, the next edge loads out_ch/out_is_rsp/out_tag/out_set and sets out_valid=1.
- Output register behaviour:
  - can_load with no eligible channel: out_valid <- 0 at the next edge.
  - out_valid && !out_ready: all out_* hold stable, even if decode_en drops. No input is accepted (no loss, no duplication).
  - Simultaneous out_ready and a new grant: the held entry retires and the new entry loads at the same edge (full throughput, 1 per cycle).
- Reset (rst=1 at an edge):
  - out_valid=0, out_ch=0, out_is_rsp=0, out_tag=0, out_set=0, rr_ptr=0.
  - in_ready=0 while rst is high.
  - Reset mid-hold drops the held entry.
- Boundaries:
  - mshr_free_cnt=0: only response-class channels are eligible.
  - mshr_free_cnt=N_MSHR: only request-class channels are eligible.
  - All channels stalled or invalid: idle, out_valid falls per the rule above.
- mshr_free_cnt is sampled in the grant cycle only. MSHR reservation is the consumer's responsibility.

Test Plan:
- Fixed priority: N_CH=4, RR_MODE=0, RSP_MASK=0001, mshr_free_cnt=3, in_valid=1111, in_addr[0]=0x0ABCDEF -> in_ready=0001; next cycle out_valid=1, out_ch=0, out_is_rsp=1, out_tag=0x0ABCDEF>>9=0x55E6, out_set=0x1EF.
- MSHR gating: mshr_free_cnt=0, in_valid=0011 -> grant ch0 only. mshr_free_cnt=8, in_valid=0011 -> grant ch1 only. mshr_free_cnt=0, in_valid=0010 -> no grant; out_valid=0 at the next edge.
- Stall: ch_stall=0110, in_valid=0110, mshr_free_cnt=4 -> no grant. Release ch_stall[2] -> in_ready=0100; out_ch=2 next cycle.
- Round-robin: RR_MODE=1, all valid for 6 cycles, out_ready=1 -> grants 0,1,2,3,0,1. Drop in_valid[1] after the first grant -> sequence 0,2,3,0.
- Back-pressure: out_valid=1 with out_ready=0 for 3 cycles -> in_ready=0000 and out_* unchanged. Raise out_ready together with in_valid[3] -> the held entry retires and ch3 loads at the same edge.
- Reset mid-hold: out_valid=1, rr_ptr=2, assert rst for one cycle -> all outputs 0, rr_ptr=0; next grant with all valid is ch0.
